interrupt_arbiter: RTL and testbench
====================================

// Module: interrupt_arbiter
// PURPOSE
//  Arbitrates interrupt requests from N peripherals (SystemTimer=0, KBDController=1, ...)
//  and presents one at a time to the CPU-side servicing FSM over the irq/iack/iend handshake.
//  Peripheral side uses pIrq/pIack/pIend. Latches edge-triggered requests so short pulses are
//  never lost, locks the offered source until the CPU finishes, and flags lost requests.
// PARAMETERS
//  N_SRC   2  number of peripheral sources; must be <= 2**ID_W - 1
//  ID_W    2  width of irq id; all-ones id = IRQ_NONE
// PORTS
//  CLK     in   1      system clock, all logic on posedge
//  RESET   in   1      synchronous, active-high reset
//  irq     out  ID_W   id of offered/in-service source; all-ones = none
//  iack    in   1      CPU claims offered interrupt (1-cycle pulse)
//  iend    in   1      CPU finished servicing (1-cycle pulse)
//  mask    in   N_SRC  1 = source enabled; masked sources stay pending, never offered
//  pIrq    in   [0:N_SRC-1] peripheral request, rising edge = new event
//  pIack   out  [0:N_SRC-1] 1-cycle pulse to granted peripheral on CPU ack
//  pIend   out  [0:N_SRC-1] 1-cycle pulse to granted peripheral on CPU end
//  oflow   out  [0:N_SRC-1] sticky: event arrived while same source already pending
// BEHAVIOUR
//  Reset: irq=all-ones, pIack=0, pIend=0, oflow=0, pending=0, pIrq_prev=0, state=IDLE.
//  Capture: pIrq_prev registers pIrq each cycle; rise[i]=pIrq[i]&~pIrq_prev[i].
//   rise sets pending[i] at that edge; a level held high does not retrigger.
//   pIrq already high when RESET drops counts as a rise on the first cycle after reset.
//   rise while pending[i]=1 -> oflow[i]<=1 (sticky until RESET); pending stays 1.
//   rise on the same edge pending[i] is cleared by iack -> set wins, pending[i] stays 1.
//  Selection: fixed priority, lowest index first, over pending & mask.
//  FSM (registered irq, no combinational path from inputs to irq):
//   IDLE:    irq=none. If any (pending&mask): irq<=selected id, ->OFFER. Else stay.
//   OFFER:   irq holds id; locked, no preemption by higher-priority arrivals or mask
//            changes. iack=1 -> pIack[id]=1 next cycle, pending[id]<=0, ->SERVICE.
//            iend without iack is ignored. iack+iend same cycle: iack taken, iend ignored.
//   SERVICE: irq holds id (in-service indicator). iack ignored. iend=1 -> pIend[id]=1 next
//            cycle, irq<=none, ->IDLE. No timeout; CPU owns service duration.
//  Latency: pIrq rise sampled at edge k -> pending after k -> irq valid after edge k+1.
//   iack sampled at edge m -> pIack pulse in cycle after m. iend same: pIend 1 cycle later.
//   After IDLE is re-entered, the next offer appears no earlier than one further edge
//   (irq shows none for >= 1 cycle between services, so the CPU sees a clean boundary).
//  pIack/pIend: exactly one bit high, exactly one cycle, only for the locked id.
//  RESET mid-OFFER/SERVICE: everything returns to reset values, no pIend is issued,
//   and pending events are discarded.
//  Width: ids compared at ID_W bits; N_SRC > 2**ID_W-1 is a parameter error (elab $error).
// TESTING
//  1 reset, pIrq=0 -> irq=2'b11, pIack=pIend=oflow=0 for 10 cycles.
//  2 pIrq[1] 1-cycle pulse at t -> irq=1 at t+2; iack -> pIack=2'b01 (bit1) one cycle;
//    iend -> pIend bit1 one cycle, irq=2'b11 next cycle.
//  3 pIrq[0] and pIrq[1] rise together -> irq=0 first; after iend, irq=1 offered 2 cycles later.
//  4 in OFFER with irq=1, pIrq[0] rises -> irq stays 1 through SERVICE; src0 offered after iend.
//  5 pIrq[0] pulsed twice before iack -> oflow[0]=1 sticky; one service only; RESET clears it.
//  6 mask=2'b10 with pIrq[0] pending -> irq stays none; set mask[0]=1 -> irq=0 two cycles later.
//  7 RESET asserted in SERVICE -> next cycle irq=2'b11, no pIend pulse, pending=0.

Source files
------------

// File: rtl/interrupt_arbiter.sv
// Interrupt arbiter: latches peripheral request edges, offers one source at a time to the
// CPU over irq/iack/iend, and relays the CPU handshake back to the granted peripheral.
//
//  state   | meaning
//  IDLE    | nothing offered, irq = none; picks the lowest enabled pending source
//  OFFER   | irq locked to the selected source, waiting for the CPU to claim it
//  SERVICE | CPU owns the source, irq shows it in service until iend
module interrupt_arbiter #(
   parameter int N_SRC = 2,
   parameter int ID_W  = 2
) (
   input  logic             CLK,
   input  logic             RESET,
   output logic [ID_W-1:0]  irq,
   input  logic             iack,
   input  logic             iend,
   input  logic [N_SRC-1:0] mask,
   input  logic [0:N_SRC-1] pIrq,
   output logic [0:N_SRC-1] pIack,
   output logic [0:N_SRC-1] pIend,
   output logic [0:N_SRC-1] oflow
);

   localparam logic [ID_W-1:0] IRQ_NONE = '1;

   generate
      if (N_SRC > (2**ID_W) - 1) begin : gParamCheck
         $error("interrupt_arbiter: N_SRC must not exceed 2**ID_W-1");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE,
      OFFER,
      SERVICE
   } stateT;

   stateT            state;
   stateT            nextState;
   logic [0:N_SRC-1] pending;
   logic [0:N_SRC-1] pIrqPrev;
   logic [0:N_SRC-1] rise;
   logic [0:N_SRC-1] clrPend;
   logic [0:N_SRC-1] ackNext;
   logic [0:N_SRC-1] endNext;
   logic [ID_W-1:0]  irqNext;
   logic [ID_W-1:0]  selId;
   logic             anyElig;

   assign rise = pIrq & ~pIrqPrev;

   // Descending scan so the lowest eligible index is the one left in selId.
   always_comb begin
      selId   = IRQ_NONE;
      anyElig = 1'b0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (pending[i] && mask[i]) begin
            selId   = ID_W'(i);
            anyElig = 1'b1;
         end
      end
   end

   always_comb begin
      nextState = state;
      irqNext   = irq;
      ackNext   = '0;
      endNext   = '0;
      clrPend   = '0;
      case (state)
         IDLE: begin
            irqNext = IRQ_NONE;
            if (anyElig) begin
               irqNext   = selId;
               nextState = OFFER;
            end
         end
         OFFER: begin
            if (iack) begin
               nextState = SERVICE;
               for (int i = 0; i < N_SRC; i++) begin
                  if (irq == ID_W'(i)) begin
                     ackNext[i] = 1'b1;
                     clrPend[i] = 1'b1;
                  end
               end
            end
         end
         SERVICE: begin
            if (iend) begin
               nextState = IDLE;
               irqNext   = IRQ_NONE;
               for (int i = 0; i < N_SRC; i++) begin
                  if (irq == ID_W'(i)) begin
                     endNext[i] = 1'b1;
                  end
               end
            end
         end
         default: begin
            nextState = IDLE;
            irqNext   = IRQ_NONE;
         end
      endcase
   end

   // A new edge beats the iack clear on the same cycle, so no event is dropped.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state    <= IDLE;
         irq      <= IRQ_NONE;
         pIack    <= '0;
         pIend    <= '0;
         oflow    <= '0;
         pending  <= '0;
         pIrqPrev <= '0;
      end else begin
         state    <= nextState;
         irq      <= irqNext;
         pIack    <= ackNext;
         pIend    <= endNext;
         oflow    <= oflow | (rise & pending);
         pending  <= (pending & ~clrPend) | rise;
         pIrqPrev <= pIrq;
      end
   end

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Bench for interrupt_arbiter: vector table, directed corner sequences and random traffic
// checked every cycle against a source-list reference model.
module tb_interrupt_arbiter;

   logic       CLK;
   logic       RESET;
   logic [1:0] irq;
   logic       iack;
   logic       iend;
   logic [1:0] mask;
   logic [0:1] pIrq;
   logic [0:1] pIack;
   logic [0:1] pIend;
   logic [0:1] oflow;

   int checks;
   int failures;

   // reference model state
   logic [0:1] mPend;
   logic [0:1] mPrev;
   logic [0:1] mOfl;
   logic [0:1] mAck;
   logic [0:1] mEnd;
   int         mLock;
   bit         mServ;

   interrupt_arbiter #(.N_SRC(2), .ID_W(2)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .irq   (irq),
      .iack  (iack),
      .iend  (iend),
      .mask  (mask),
      .pIrq  (pIrq),
      .pIack (pIack),
      .pIend (pIend),
      .oflow (oflow)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [0:1] p;
      logic [1:0] m;
      logic       a;
      logic       e;
      logic [1:0] xIrq;
      logic [0:1] xAck;
      logic [0:1] xEnd;
   } vecT;

   vecT tbl [14];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: a source is either idle, offered or in service; the CPU sees one at a time.
   task automatic modelStep();
      logic [0:1] r;
      logic [0:1] oldP;
      if (RESET) begin
         mPend = '0; mPrev = '0; mOfl = '0; mAck = '0; mEnd = '0;
         mLock = -1; mServ = 0;
      end else begin
         r    = pIrq & ~mPrev;
         oldP = mPend;
         mAck = '0;
         mEnd = '0;
         if (mLock < 0) begin
            for (int i = 0; i < 2; i++)
               if (mLock < 0 && oldP[i] && mask[i]) mLock = i;
            mServ = 0;
         end else if (!mServ) begin
            if (iack) begin
               mAck[mLock]  = 1'b1;
               mPend[mLock] = 1'b0;
               mServ        = 1;
            end
         end else if (iend) begin
            mEnd[mLock] = 1'b1;
            mLock       = -1;
         end
         mOfl  = mOfl | (r & oldP);
         mPend = mPend | r;
         mPrev = pIrq;
      end
   endtask

   task automatic tick();
      logic [1:0] ei;
      @(posedge CLK);
      modelStep();
      #1;
      ei = (mLock < 0) ? 2'b11 : 2'(mLock);
      check("model", {24'd0, irq, pIack, pIend, oflow}, {24'd0, ei, mAck, mEnd, mOfl});
   endtask

   task automatic cyc(input logic [0:1] p, input logic a, input logic e);
      pIrq = p;
      iack = a;
      iend = e;
      tick();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      RESET = 1'b1; iack = 1'b0; iend = 1'b0; mask = 2'b11; pIrq = 2'b00;

      tbl[0]  = '{2'b01, 2'b11, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00};
      tbl[1]  = '{2'b00, 2'b11, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00};
      tbl[2]  = '{2'b00, 2'b11, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00};
      tbl[3]  = '{2'b00, 2'b11, 1'b1, 1'b0, 2'b01, 2'b01, 2'b00};
      tbl[4]  = '{2'b00, 2'b11, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00};
      tbl[5]  = '{2'b00, 2'b11, 1'b0, 1'b1, 2'b11, 2'b00, 2'b01};
      tbl[6]  = '{2'b00, 2'b11, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00};
      tbl[7]  = '{2'b10, 2'b10, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00};
      tbl[8]  = '{2'b00, 2'b10, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00};
      tbl[9]  = '{2'b00, 2'b10, 1'b1, 1'b0, 2'b11, 2'b00, 2'b00};
      tbl[10] = '{2'b00, 2'b11, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
      tbl[11] = '{2'b00, 2'b11, 1'b1, 1'b1, 2'b00, 2'b10, 2'b00};
      tbl[12] = '{2'b00, 2'b11, 1'b0, 1'b1, 2'b11, 2'b00, 2'b10};
      tbl[13] = '{2'b00, 2'b11, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00};

      // reset held: outputs idle
      for (int i = 0; i < 10; i++) begin
         cyc(2'b00, 1'b0, 1'b0);
         check("rst_out", {24'd0, irq, pIack, pIend, oflow}, {24'd0, 8'b11_00_00_00});
      end
      RESET = 1'b0;

      for (int i = 0; i < 14; i++) begin
         mask = tbl[i].m;
         cyc(tbl[i].p, tbl[i].a, tbl[i].e);
         check($sformatf("vec%0d_irq", i), {30'd0, irq}, {30'd0, tbl[i].xIrq});
         check($sformatf("vec%0d_ack", i), {30'd0, pIack}, {30'd0, tbl[i].xAck});
         check($sformatf("vec%0d_end", i), {30'd0, pIend}, {30'd0, tbl[i].xEnd});
      end

      // simultaneous rise: src0 first, src1 after a one-cycle gap
      cyc(2'b11, 1'b0, 1'b0);
      cyc(2'b00, 1'b0, 1'b0);  check("sim_first", {30'd0, irq}, 32'd0);
      cyc(2'b00, 1'b1, 1'b0);  check("sim_ack0", {30'd0, pIack}, 32'b10);
      cyc(2'b00, 1'b0, 1'b1);  check("sim_gap", {30'd0, irq}, 32'd3);
      cyc(2'b00, 1'b0, 1'b0);  check("sim_second", {30'd0, irq}, 32'd1);
      cyc(2'b00, 1'b1, 1'b0);
      cyc(2'b00, 1'b0, 1'b1);  check("sim_end1", {30'd0, pIend}, 32'b01);
      cyc(2'b00, 1'b0, 1'b0);

      // no preemption while src1 is locked
      cyc(2'b01, 1'b0, 1'b0);
      cyc(2'b00, 1'b0, 1'b0);  check("lock_offer", {30'd0, irq}, 32'd1);
      cyc(2'b10, 1'b0, 1'b0);  check("lock_hold", {30'd0, irq}, 32'd1);
      cyc(2'b00, 1'b1, 1'b0);  check("lock_ack", {30'd0, pIack}, 32'b01);
      cyc(2'b00, 1'b0, 1'b0);  check("lock_serv", {30'd0, irq}, 32'd1);
      cyc(2'b00, 1'b0, 1'b1);
      cyc(2'b00, 1'b0, 1'b0);  check("lock_next", {30'd0, irq}, 32'd0);
      cyc(2'b00, 1'b1, 1'b0);
      cyc(2'b00, 1'b0, 1'b1);
      cyc(2'b00, 1'b0, 1'b0);

      // overflow: two events on masked src0, one service, sticky until reset
      mask = 2'b00;
      cyc(2'b10, 1'b0, 1'b0);
      cyc(2'b00, 1'b0, 1'b0);
      cyc(2'b10, 1'b0, 1'b0);  check("ofl_set", {30'd0, oflow}, 32'b10);
      cyc(2'b00, 1'b0, 1'b0);  check("ofl_masked", {30'd0, irq}, 32'd3);
      mask = 2'b11;
      cyc(2'b00, 1'b0, 1'b0);  check("ofl_offer", {30'd0, irq}, 32'd0);
      cyc(2'b00, 1'b1, 1'b0);
      cyc(2'b00, 1'b0, 1'b1);
      cyc(2'b00, 1'b0, 1'b0);
      cyc(2'b00, 1'b0, 1'b0);  check("ofl_once", {30'd0, irq}, 32'd3);
      check("ofl_sticky", {30'd0, oflow}, 32'b10);
      RESET = 1'b1;
      cyc(2'b00, 1'b0, 1'b0);  check("ofl_clr", {30'd0, oflow}, 32'b00);
      RESET = 1'b0;

      // reset during SERVICE: no pIend, queued src1 discarded
      cyc(2'b11, 1'b0, 1'b0);
      cyc(2'b00, 1'b0, 1'b0);
      cyc(2'b00, 1'b1, 1'b0);
      RESET = 1'b1;
      cyc(2'b00, 1'b0, 1'b1);
      check("rsv_irq", {30'd0, irq}, 32'd3);
      check("rsv_noend", {30'd0, pIend}, 32'b00);
      RESET = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc(2'b00, 1'b0, 1'b0);
         check("rsv_discard", {30'd0, irq}, 32'd3);
      end

      // random traffic against the model
      for (int n = 0; n < 4000; n++) begin
         logic [0:1] p;
         p = pIrq;
         if ($urandom_range(3) == 0) p[0] = ~p[0];
         if ($urandom_range(3) == 0) p[1] = ~p[1];
         if ($urandom_range(15) == 0) mask = 2'($urandom_range(3));
         RESET = ($urandom_range(199) == 0);
         cyc(p, 1'($urandom_range(3) == 0), 1'($urandom_range(3) == 0));
      end
      RESET = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
